// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared constants and helpers for the 5-stage core pipeline registers
package pipe_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_LANES = 4;
    localparam int STAT_W        = 32;

    // sll $0,$0,0 encodes as all zeros
    localparam logic [31:0] NOP_INST = 32'h0000_0000;

    // Lane assignments per stage register; lane 0 is always the instruction
    localparam int IFID_INST  = 0;
    localparam int IFID_PC4   = 1;

    localparam int IDEX_INST  = 0;
    localparam int IDEX_PC4   = 1;
    localparam int IDEX_RS    = 2;
    localparam int IDEX_RT    = 3;
    localparam int IDEX_IMM   = 4;

    localparam int EXMEM_INST = 0;
    localparam int EXMEM_AO   = 1;
    localparam int EXMEM_RT   = 2;
    localparam int EXMEM_DO   = 3;

    localparam int MEMWB_INST = 0;
    localparam int MEMWB_AO   = 1;
    localparam int MEMWB_DR   = 2;

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/pipe_lane_reg.sv
// rtl/pipe_lane_reg.sv - one pipeline lane: async reset to 0, sync clear to CLR_VAL, enable
module pipe_lane_reg #(
    parameter int               WIDTH   = pipe_pkg::DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (clear) begin
            q <= CLR_VAL;
        end else if (enable) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_reg.sv
// rtl/pipe_stage_reg.sv - inter-stage pipeline register with stall/flush; PIPE_REG_STATS_EN adds counters
module pipe_stage_reg #(
    parameter int               WIDTH    = pipe_pkg::DEFAULT_WIDTH,
    parameter int               LANES    = pipe_pkg::DEFAULT_LANES,
    parameter logic [WIDTH-1:0] NOP_INST = WIDTH'(pipe_pkg::NOP_INST)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   flush,
    input  logic                   in_valid,
    input  logic [LANES*WIDTH-1:0] data_in,
    output logic                   out_valid,
    output logic [LANES*WIDTH-1:0] data_out
`ifdef PIPE_REG_STATS_EN
    ,
    output logic [31:0]            stall_cnt,
    output logic [31:0]            flush_cnt
`endif
);

    import pipe_pkg::*;

    pipe_lane_reg #(
        .WIDTH   (1),
        .CLR_VAL (1'b0)
    ) u_valid (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .clear  (flush),
        .d      (in_valid),
        .q      (out_valid)
    );

    // A flushed stage carries a NOP in the instruction lane and zeros elsewhere
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        localparam logic [WIDTH-1:0] LANE_CLR = (k == 0) ? NOP_INST : '0;

        pipe_lane_reg #(
            .WIDTH   (WIDTH),
            .CLR_VAL (LANE_CLR)
        ) u_lane (
            .clk    (clk),
            .reset  (reset),
            .enable (enable),
            .clear  (flush),
            .d      (data_in[k*WIDTH +: WIDTH]),
            .q      (data_out[k*WIDTH +: WIDTH])
        );
    end

`ifdef PIPE_REG_STATS_EN
    // Stalls only count while the stage holds a real instruction
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (flush) begin
                flush_cnt <= sat_inc(flush_cnt);
            end
            if (!flush && !enable && out_valid) begin
                stall_cnt <= sat_inc(stall_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb/tb_pipe_stage_reg.sv - directed table plus LANES=1/6 random sweep for pipe_stage_reg
module tb_pipe_stage_reg;

    localparam int W  = 32;
    localparam int L  = 4;
    localparam logic [31:0] NOP6 = 32'h0000_0020;

    typedef struct {
        logic         flush;
        logic         enable;
        logic         in_valid;
        logic [127:0] din;
        logic         exp_valid;
        logic [127:0] exp_dout;
        string        name;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         enable = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic [127:0] data_in = '0;
    logic         out_valid;
    logic [127:0] data_out;

    logic         s_enable = 1'b0;
    logic         s_flush = 1'b0;
    logic         s_in_valid = 1'b0;
    logic [191:0] s_din = '0;
    logic         s1_valid;
    logic [31:0]  s1_dout;
    logic         s6_valid;
    logic [191:0] s6_dout;

    logic         m1_valid;
    logic [31:0]  m1_dout;
    logic         m6_valid;
    logic [191:0] m6_dout;

    int checks = 0;
    int errors = 0;
    vec_t tbl[9];
    logic [127:0] prev;

`ifdef PIPE_REG_STATS_EN
    logic [31:0] stall_cnt, flush_cnt, s1_stall, s1_flush, s6_stall, s6_flush;
    logic [31:0] m_stall, m_flush;
`endif

    always #5 clk = ~clk;

    pipe_stage_reg #(.WIDTH(W), .LANES(L)) dut (
        .clk(clk), .reset(reset), .enable(enable), .flush(flush),
        .in_valid(in_valid), .data_in(data_in),
        .out_valid(out_valid), .data_out(data_out)
`ifdef PIPE_REG_STATS_EN
        , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
    );

    pipe_stage_reg #(.WIDTH(W), .LANES(1)) dut_l1 (
        .clk(clk), .reset(reset), .enable(s_enable), .flush(s_flush),
        .in_valid(s_in_valid), .data_in(s_din[31:0]),
        .out_valid(s1_valid), .data_out(s1_dout)
`ifdef PIPE_REG_STATS_EN
        , .stall_cnt(s1_stall), .flush_cnt(s1_flush)
`endif
    );

    pipe_stage_reg #(.WIDTH(W), .LANES(6), .NOP_INST(NOP6)) dut_l6 (
        .clk(clk), .reset(reset), .enable(s_enable), .flush(s_flush),
        .in_valid(s_in_valid), .data_in(s_din),
        .out_valid(s6_valid), .data_out(s6_dout)
`ifdef PIPE_REG_STATS_EN
        , .stall_cnt(s6_stall), .flush_cnt(s6_flush)
`endif
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        prev = {32'h0000_00AA, 32'h1234_5678, 32'hDEAD_BEEF, 32'h8C01_0004};
        tbl[0] = '{1'b0, 1'b1, 1'b1, prev, 1'b1, prev, "advance"};
        tbl[1] = '{1'b0, 1'b0, 1'b0, {4{32'h1111_1111}}, 1'b1, prev, "stall1"};
        tbl[2] = '{1'b0, 1'b0, 1'b1, {4{32'h2222_2222}}, 1'b1, prev, "stall2"};
        tbl[3] = '{1'b0, 1'b0, 1'b0, {4{32'h3333_3333}}, 1'b1, prev, "stall3"};
        tbl[4] = '{1'b1, 1'b1, 1'b1, {4{32'hFFFF_FFFF}}, 1'b0, 128'h0, "flush_prio"};
        tbl[5] = '{1'b0, 1'b1, 1'b0,
                   {32'h0000_0033, 32'h0000_0022, 32'h0000_0011, 32'h2008_0005}, 1'b0,
                   {32'h0000_0033, 32'h0000_0022, 32'h0000_0011, 32'h2008_0005}, "bubble"};
        tbl[6] = '{1'b0, 1'b1, 1'b1,
                   {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'h0232_2020}, 1'b1,
                   {32'hCAFE_0003, 32'hCAFE_0002, 32'hCAFE_0001, 32'h0232_2020}, "advance2"};
        tbl[7] = '{1'b1, 1'b0, 1'b1, {4{32'h5555_5555}}, 1'b0, 128'h0, "flush_no_en"};
        tbl[8] = '{1'b0, 1'b0, 1'b1, {4{32'h6666_6666}}, 1'b0, 128'h0, "stall_bubble"};

        // Reset state, observed before any clock edge
        data_in = {4{32'hA5A5_A5A5}};
        enable  = 1'b1;
        in_valid = 1'b1;
        #1;
        check("reset_dout", 256'(data_out), 256'h0);
        check("reset_valid", 256'(out_valid), 256'h0);
`ifdef PIPE_REG_STATS_EN
        check("reset_stall_cnt", 256'(stall_cnt), 256'h0);
        check("reset_flush_cnt", 256'(flush_cnt), 256'h0);
`endif
        tick();
        check("reset_hold_dout", 256'(data_out), 256'h0);
        reset = 1'b0;

        foreach (tbl[i]) begin
            flush    = tbl[i].flush;
            enable   = tbl[i].enable;
            in_valid = tbl[i].in_valid;
            data_in  = tbl[i].din;
            tick();
            check({tbl[i].name, "_dout"}, 256'(data_out), 256'(tbl[i].exp_dout));
            check({tbl[i].name, "_valid"}, 256'(out_valid), 256'(tbl[i].exp_valid));
        end
`ifdef PIPE_REG_STATS_EN
        check("stall_cnt", 256'(stall_cnt), 256'd3);
        check("flush_cnt", 256'(flush_cnt), 256'd2);
`endif

        // Reset asserted between edges takes effect without a clock edge
        flush = 1'b0; enable = 1'b1; in_valid = 1'b1;
        data_in = {32'h0BAD_F00D, 32'h0000_1234, 32'h7777_0000, 32'h8C01_0008};
        tick();
        check("preload_dout", 256'(data_out), 256'(data_in));
        #2 reset = 1'b1;
        #1;
        check("midcyc_reset_dout", 256'(data_out), 256'h0);
        check("midcyc_reset_valid", 256'(out_valid), 256'h0);
        tick();
        check("reset_held_dout", 256'(data_out), 256'h0);
        check("reset_held_valid", 256'(out_valid), 256'h0);
`ifdef PIPE_REG_STATS_EN
        check("midcyc_reset_flush_cnt", 256'(flush_cnt), 256'h0);
`endif
        #1 reset = 1'b0;
        tick();
        check("post_reset_capture", 256'(data_out), 256'(data_in));
        check("post_reset_valid", 256'(out_valid), 256'h1);

        // Random sweep on LANES=1 and LANES=6 against a behavioural model
        reset = 1'b1;
        #1;
        m1_valid = 1'b0; m1_dout = '0;
        m6_valid = 1'b0; m6_dout = '0;
`ifdef PIPE_REG_STATS_EN
        m_stall = '0; m_flush = '0;
`endif
        tick();
        reset = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            s_flush    = ($urandom_range(0, 7) == 0);
            s_enable   = ($urandom_range(0, 3) != 0);
            s_in_valid = $urandom_range(0, 1) == 1;
            for (int k = 0; k < 6; k++) s_din[k*32 +: 32] = $urandom();
            tick();
`ifdef PIPE_REG_STATS_EN
            if (s_flush) m_flush = m_flush + 1;
            else if (!s_enable && m6_valid) m_stall = m_stall + 1;
`endif
            if (s_flush) begin
                m1_valid = 1'b0; m1_dout = pipe_pkg::NOP_INST;
                m6_valid = 1'b0; m6_dout = {160'h0, NOP6};
            end else if (s_enable) begin
                m1_valid = s_in_valid; m1_dout = s_din[31:0];
                m6_valid = s_in_valid; m6_dout = s_din;
            end
            check("sweep_l1_dout", 256'(s1_dout), 256'(m1_dout));
            check("sweep_l1_valid", 256'(s1_valid), 256'(m1_valid));
            check("sweep_l6_dout", 256'(s6_dout), 256'(m6_dout));
            check("sweep_l6_valid", 256'(s6_valid), 256'(m6_valid));
`ifdef PIPE_REG_STATS_EN
            check("sweep_l6_stall_cnt", 256'(s6_stall), 256'(m_stall));
            check("sweep_l6_flush_cnt", 256'(s6_flush), 256'(m_flush));
            check("sweep_l1_flush_cnt", 256'(s1_flush), 256'(m_flush));
`endif
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
